mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM stage of the 5-stage RV32I pipeline.
- Consumes the EX stage's registered outputs: decode info, ALU result/address and store data.
- Drives a valid/ready data-bus interface, performs byte-lane steering and load sign/zero extension, and raises a stall request while a bus access is outstanding.
- Its registered mem_out/info_ff pair is the MEM→EX forwarding source and the MEM/WB pipeline register.

Parameters:
STORE_WAIT_RESP, 0, 1 = stores wait for dbus_resp_valid before completing; 0 = a store completes on request acceptance (posted).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req  out  PipeRequest  stall_req = MEM access outstanding; flush_req constant 4'b0000
pipe  in  PipeControl  global stall/flush for this stage
info  in  DecodeInfo  EX-stage registered decode info (enable, mem_read, mem_write, funct3, rd, rd_valid, ...)
alu_in  in  32  EX result; effective address for loads/stores
r2_in  in  32  store data (forwarded rs2)
dbus_req_valid  out  1  request valid
dbus_req_ready  in  1  request accepted when valid&&ready
dbus_addr  out  32  {alu_in[31:2],2'b00}
dbus_we  out  1  1 = store
dbus_wstrb  out  4  byte enables (0 for loads)
dbus_wdata  out  32  lane-replicated store data
dbus_resp_valid  in  1  response/read data valid (one-cycle pulse)
dbus_rdata  in  32  read word
mem_out  out  32  registered stage result (load data or alu_in)
info_ff  out  DecodeInfo  registered decode info
misalign  out  1  registered one-cycle pulse: misaligned access suppressed

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_out=0, info_ff=0, misalign=0, load_buf=0; dbus_req_valid=0 and stall_req=0 immediately.
- mem_op = info.enable && (info.mem_read || info.mem_write). mis = (half && alu_in[0]) || (word && alu_in[1:0]!=0).
- States:
  - IDLE: if mem_op && !mis, dbus_req_valid=1 and stall_req=1 (both combinational).
    - Handshake: load → WAIT_RESP; store → DONE, or WAIT_RESP if STORE_WAIT_RESP=1.
    - No handshake: stay in IDLE with valid held. Inputs are stable because stall_req holds EX.
  - WAIT_RESP: stall_req=1, dbus_req_valid=0. On dbus_resp_valid: load_buf<=extracted data; → DONE.
  - DONE: stall_req=0, no bus request. On !pipe.stall → IDLE. A stall imposed by another stage must never re-issue the access.
  - DRAIN: entered from WAIT_RESP on pipe.flush. stall_req=0. Discard the response; on dbus_resp_valid → IDLE.
- A flush in IDLE while valid is not yet accepted: drop the request in the same cycle.
- Load extraction, with lane = alu_in[1:0]:
  - LB 000 / LBU 100: byte lane, sign/zero-extended.
  - LH 001 / LHU 101: half alu_in[1], sign/zero-extended.
  - LW 010: full word.
  - Other funct3: data 0.
- Store steering:
  - SB: wstrb = 4'b0001<<lane; wdata = {4{r2_in[7:0]}}.
  - SH: wstrb = 4'b0011<<{alu_in[1],1'b0}; wdata = {2{r2_in[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = r2_in.
  - dbus_addr is always word-aligned.
- Misaligned access:
  - No bus request, stall_req=0.
  - On advance: misalign<=1 for one cycle, info_ff<=info with enable=0, mem_out<=0.
- Output register:
  - pipe.flush: mem_out<=0, info_ff<=0.
  - Else pipe.stall: hold.
  - Else: info_ff<=info; mem_out <= (info.enable && info.mem_read && !mis) ? load_buf : (info.enable ? alu_in : 0).
- Load data bypass: when a response and advance coincide, mem_out takes the extracted dbus_rdata directly. This only arises in the DONE-less path, which is unreachable by design; load_buf is always written one cycle before advance.
- Stalled stage: EX must not advance while stall_req=1. The global controller ORs stall_req into pipe.stall.
- Non-memory instructions: pass through with zero added latency.

Test Plan:
- LW 0x100, ready=1, resp next cycle with rdata=0xDEADBEEF → valid 1 cycle, stall_req high 2 cycles; next advance mem_out=0xDEADBEEF, info_ff.rd preserved.
- LB 0x103 with rdata=0x80FF_0000 → mem_out=0xFFFFFF80; LBU at the same address → 0x00000080; LHU 0x102 → 0x000080FF.
- SH 0x206 with r2_in=0x1234ABCD, ready low 3 cycles → valid held 4 cycles, addr=0x204, wstrb=1100, wdata=0xABCDABCD; DONE, no resp wait (STORE_WAIT_RESP=0).
- LW 0x101 → no dbus_req_valid, stall_req=0, misalign pulses 1 cycle, info_ff.enable=0, mem_out=0.
- Load completes, then external pipe.stall held 5 extra cycles → exactly one bus request, stall_req=0 during hold, mem_out=loaded value after release.
- Flush during WAIT_RESP, then resp arrives 2 cycles later → DRAIN, response discarded, mem_out/info_ff=0, next load issues normally. Assert rst mid-WAIT_RESP → valid/stall_req drop immediately, state IDLE.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: MEM stage of a 5-stage RV32I pipeline.
// Issues the EX stage's load/store on a valid/ready data bus, steers store
// bytes onto lanes, extracts and extends load data, and holds the pipeline
// (stall_req) while an access is outstanding. The registered mem_out/info_ff
// pair is both the MEM->EX forwarding source and the MEM/WB register.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req               stall_req (access outstanding), flush_req (always 0)
//   pipe              global stall/flush for this stage
//   info              EX-stage registered decode info
//   alu_in            EX result / effective address
//   r2_in             store data
//   dbus_*            data-bus request (valid/ready) and response (pulse)
//   mem_out           registered stage result
//   info_ff           registered decode info
//   misalign          one-cycle pulse: misaligned access suppressed

typedef struct packed {
  logic       stall_req;
  logic [3:0] flush_req;
} pipe_request_t;

typedef struct packed {
  logic stall;
  logic flush;
} pipe_control_t;

typedef struct packed {
  logic       enable;
  logic       mem_read;
  logic       mem_write;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       rd_valid;
} decode_info_t;

module mem_access #(
  parameter bit STORE_WAIT_RESP = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  output pipe_request_t req,
  input  pipe_control_t pipe,
  input  decode_info_t  info,
  input  logic [31:0]   alu_in,
  input  logic [31:0]   r2_in,
  output logic          dbus_req_valid,
  input  logic          dbus_req_ready,
  output logic [31:0]   dbus_addr,
  output logic          dbus_we,
  output logic [3:0]    dbus_wstrb,
  output logic [31:0]   dbus_wdata,
  input  logic          dbus_resp_valid,
  input  logic [31:0]   dbus_rdata,
  output logic [31:0]   mem_out,
  output decode_info_t  info_ff,
  output logic          misalign
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    DONE,
    DRAIN
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              stall_c;
  logic              mem_op;
  logic              is_half;
  logic              is_word;
  logic              mis;
  logic              resp_take;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   load_buf;
  logic [XLEN-1:0]   load_val;
  decode_info_t      info_masked;

  // Access classification
  always_comb begin
    mem_op  = info.enable && (info.mem_read || info.mem_write);
    is_half = (info.funct3[1:0] == 2'b01);
    is_word = (info.funct3[1:0] == 2'b10);
    mis     = (is_half && alu_in[0]) || (is_word && (alu_in[1:0] != 2'b00));
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    byte_sel = dbus_rdata[7:0];
    case (alu_in[1:0])
      2'd0:    byte_sel = dbus_rdata[7:0];
      2'd1:    byte_sel = dbus_rdata[15:8];
      2'd2:    byte_sel = dbus_rdata[23:16];
      default: byte_sel = dbus_rdata[31:24];
    endcase
    half_sel  = alu_in[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    load_data = '0;
    case (info.funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      3'b010:  load_data = dbus_rdata;
      default: load_data = '0;
    endcase
  end

  // Store lane steering; address is always word-aligned
  always_comb begin
    dbus_addr  = {alu_in[31:2], 2'b00};
    dbus_we    = info.mem_write;
    dbus_wstrb = '0;
    dbus_wdata = '0;
    if (info.mem_write) begin
      case (info.funct3[1:0])
        2'b00: begin
          dbus_wstrb = 4'b0001 << alu_in[1:0];
          dbus_wdata = {4{r2_in[7:0]}};
        end
        2'b01: begin
          dbus_wstrb = 4'b0011 << {alu_in[1], 1'b0};
          dbus_wdata = {2{r2_in[15:0]}};
        end
        2'b10: begin
          dbus_wstrb = 4'b1111;
          dbus_wdata = r2_in;
        end
        default: begin
          dbus_wstrb = '0;
          dbus_wdata = '0;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state and combinational bus/stall outputs
  always_comb begin
    state_next     = state;
    dbus_req_valid = 1'b0;
    stall_c        = 1'b0;
    case (state)
      IDLE: begin
        // A flush drops a not-yet-accepted request in the same cycle
        if (mem_op && !mis && !pipe.flush) begin
          dbus_req_valid = 1'b1;
          stall_c        = 1'b1;
          if (dbus_req_ready) begin
            state_next = (info.mem_read || STORE_WAIT_RESP) ? WAIT_RESP : DONE;
          end
        end
      end
      WAIT_RESP: begin
        stall_c = 1'b1;
        if (pipe.flush) begin
          state_next = dbus_resp_valid ? IDLE : DRAIN;
        end else if (dbus_resp_valid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Waiting only for the pipeline to advance; never re-issue
        if (pipe.flush || !pipe.stall) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        // The drain itself does not stall; a fresh memory op waits for it
        stall_c = mem_op;
        if (dbus_resp_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      dbus_req_valid = 1'b0;
      stall_c        = 1'b0;
    end
  end

  always_comb begin
    req.stall_req = stall_c;
    req.flush_req = 4'b0000;
  end

  // Response capture; the bypass covers a response coinciding with advance
  always_comb begin
    resp_take = (state == WAIT_RESP) && dbus_resp_valid && !pipe.flush;
    load_val  = resp_take ? load_data : load_buf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_buf <= '0;
    end else if (resp_take && info.mem_read) begin
      load_buf <= load_data;
    end
  end

  always_comb begin
    info_masked        = info;
    info_masked.enable = 1'b0;
  end

  // MEM/WB output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_out  <= '0;
      info_ff  <= '0;
      misalign <= 1'b0;
    end else if (pipe.flush) begin
      mem_out  <= '0;
      info_ff  <= '0;
      misalign <= 1'b0;
    end else if (!pipe.stall) begin
      if (mem_op && mis) begin
        mem_out  <= '0;
        info_ff  <= info_masked;
        misalign <= 1'b1;
      end else begin
        info_ff  <= info;
        misalign <= 1'b0;
        if (info.enable && info.mem_read) begin
          mem_out <= load_val;
        end else if (info.enable) begin
          mem_out <= alu_in;
        end else begin
          mem_out <= '0;
        end
      end
    end else begin
      misalign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access. The bench plays the global
// controller (pipe.stall = stall_req | external stall) and the data bus.
// Each step drives inputs just after a rising edge and checks outputs
// within the same cycle.

module tb_mem_access;

  logic          clk;
  logic          rst;
  pipe_request_t req;
  pipe_control_t pipe;
  decode_info_t  info;
  logic [31:0]   alu_in;
  logic [31:0]   r2_in;
  logic          dbus_req_valid;
  logic          dbus_req_ready;
  logic [31:0]   dbus_addr;
  logic          dbus_we;
  logic [3:0]    dbus_wstrb;
  logic [31:0]   dbus_wdata;
  logic          dbus_resp_valid;
  logic [31:0]   dbus_rdata;
  logic [31:0]   mem_out;
  decode_info_t  info_ff;
  logic          misalign;

  logic          ext_stall;
  logic          ext_flush;
  logic          hs_clr;
  int            hs_count;
  int            tests;
  int            fails;

  mem_access #(.STORE_WAIT_RESP(1'b0)) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .pipe            (pipe),
    .info            (info),
    .alu_in          (alu_in),
    .r2_in           (r2_in),
    .dbus_req_valid  (dbus_req_valid),
    .dbus_req_ready  (dbus_req_ready),
    .dbus_addr       (dbus_addr),
    .dbus_we         (dbus_we),
    .dbus_wstrb      (dbus_wstrb),
    .dbus_wdata      (dbus_wdata),
    .dbus_resp_valid (dbus_resp_valid),
    .dbus_rdata      (dbus_rdata),
    .mem_out         (mem_out),
    .info_ff         (info_ff),
    .misalign        (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pipe = '{stall: req.stall_req | ext_stall, flush: ext_flush};

  // Accepted bus requests
  always @(posedge clk) begin
    if (hs_clr) hs_count <= 0;
    else if (dbus_req_valid && dbus_req_ready) hs_count <= hs_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic decode_info_t mk(input logic en, input logic rdop, input logic wrop,
                                      input logic [2:0] f3, input logic [4:0] rd);
    decode_info_t d;
    d.enable    = en;
    d.mem_read  = rdop;
    d.mem_write = wrop;
    d.funct3    = f3;
    d.rd        = rd;
    d.rd_valid  = rdop;
    return d;
  endfunction

  task automatic bubble();
    info   = '0;
    alu_in = '0;
  endtask

  // Load with ready=1 and a response one cycle later; checks the advanced result
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
    info           = mk(1'b1, 1'b1, 1'b0, f3, 5'd3);
    alu_in         = addr;
    dbus_req_ready = 1'b1;
    cyc();
    dbus_req_ready  = 1'b0;
    dbus_resp_valid = 1'b1;
    dbus_rdata      = rdata;
    cyc();
    dbus_resp_valid = 1'b0;
    dbus_rdata      = '0;
    cyc();
    bubble();
    #1;
    chk(tag, mem_out, exp);
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    rst             = 1'b1;
    ext_stall       = 1'b0;
    ext_flush       = 1'b0;
    hs_clr          = 1'b1;
    dbus_req_ready  = 1'b0;
    dbus_resp_valid = 1'b0;
    dbus_rdata      = '0;
    r2_in           = '0;
    bubble();
    #1;
    chk("rst_valid", 32'(dbus_req_valid), 32'd0);
    chk("rst_stall", 32'(req.stall_req), 32'd0);
    chk("rst_mem_out", mem_out, 32'd0);
    chk("rst_info_ff", 32'(info_ff), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("flush_req", 32'(req.flush_req), 32'd0);
    cyc();
    cyc();
    rst    = 1'b0;
    hs_clr = 1'b0;

    // LW 0x100: valid one cycle, stall two cycles, result on advance
    info           = mk(1'b1, 1'b1, 1'b0, 3'b010, 5'd5);
    alu_in         = 32'h0000_0100;
    dbus_req_ready = 1'b1;
    #1;
    chk("lw_valid_c0", 32'(dbus_req_valid), 32'd1);
    chk("lw_stall_c0", 32'(req.stall_req), 32'd1);
    chk("lw_addr", dbus_addr, 32'h0000_0100);
    chk("lw_wstrb", 32'(dbus_wstrb), 32'd0);
    chk("lw_we", 32'(dbus_we), 32'd0);
    cyc();
    dbus_req_ready  = 1'b0;
    dbus_resp_valid = 1'b1;
    dbus_rdata      = 32'hDEAD_BEEF;
    #1;
    chk("lw_valid_c1", 32'(dbus_req_valid), 32'd0);
    chk("lw_stall_c1", 32'(req.stall_req), 32'd1);
    cyc();
    dbus_resp_valid = 1'b0;
    dbus_rdata      = '0;
    #1;
    chk("lw_stall_c2", 32'(req.stall_req), 32'd0);
    chk("lw_valid_c2", 32'(dbus_req_valid), 32'd0);
    cyc();
    bubble();
    #1;
    chk("lw_mem_out", mem_out, 32'hDEAD_BEEF);
    chk("lw_rd", 32'(info_ff.rd), 32'd5);
    chk("lw_enable", 32'(info_ff.enable), 32'd1);

    // Sub-word load extraction
    run_load("lb_103", 3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
    run_load("lbu_103", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
    run_load("lhu_102", 3'b101, 32'h0000_0102, 32'h80FF_0000, 32'h0000_80FF);
    run_load("lh_102", 3'b001, 32'h0000_0102, 32'h80FF_0000, 32'hFFFF_80FF);
    run_load("lb_101", 3'b000, 32'h0000_0101, 32'h0000_7F00, 32'h0000_007F);

    // SB / SW steering (not accepted, request dropped by changing EX)
    info   = mk(1'b1, 1'b0, 1'b1, 3'b000, 5'd0);
    alu_in = 32'h0000_0201;
    r2_in  = 32'hAAAA_AA55;
    #1;
    chk("sb_wstrb", 32'(dbus_wstrb), 32'h2);
    chk("sb_wdata", dbus_wdata, 32'h5555_5555);
    info  = mk(1'b1, 1'b0, 1'b1, 3'b010, 5'd0);
    alu_in = 32'h0000_0208;
    r2_in = 32'h0102_0304;
    #1;
    chk("sw_wstrb", 32'(dbus_wstrb), 32'hF);
    chk("sw_wdata", dbus_wdata, 32'h0102_0304);

    // SH 0x206 with ready low 3 cycles, posted completion
    info   = mk(1'b1, 1'b0, 1'b1, 3'b001, 5'd0);
    alu_in = 32'h0000_0206;
    r2_in  = 32'h1234_ABCD;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sh_valid_wait", 32'(dbus_req_valid), 32'd1);
      cyc();
    end
    dbus_req_ready = 1'b1;
    #1;
    chk("sh_valid", 32'(dbus_req_valid), 32'd1);
    chk("sh_addr", dbus_addr, 32'h0000_0204);
    chk("sh_wstrb", 32'(dbus_wstrb), 32'hC);
    chk("sh_wdata", dbus_wdata, 32'hABCD_ABCD);
    chk("sh_we", 32'(dbus_we), 32'd1);
    cyc();
    dbus_req_ready = 1'b0;
    #1;
    chk("sh_done_stall", 32'(req.stall_req), 32'd0);
    chk("sh_done_valid", 32'(dbus_req_valid), 32'd0);
    cyc();
    bubble();
    #1;
    chk("sh_mem_out", mem_out, 32'h0000_0206);

    // Misaligned LW 0x101
    info   = mk(1'b1, 1'b1, 1'b0, 3'b010, 5'd7);
    alu_in = 32'h0000_0101;
    #1;
    chk("mis_valid", 32'(dbus_req_valid), 32'd0);
    chk("mis_stall", 32'(req.stall_req), 32'd0);
    cyc();
    bubble();
    #1;
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_enable", 32'(info_ff.enable), 32'd0);
    chk("mis_rd", 32'(info_ff.rd), 32'd7);
    chk("mis_mem_out", mem_out, 32'd0);
    cyc();
    chk("mis_pulse_end", 32'(misalign), 32'd0);

    // Non-memory pass-through, then bubble clears the result
    info   = mk(1'b1, 1'b0, 1'b0, 3'b000, 5'd4);
    alu_in = 32'h0000_55AA;
    #1;
    chk("alu_stall", 32'(req.stall_req), 32'd0);
    cyc();
    bubble();
    #1;
    chk("alu_mem_out", mem_out, 32'h0000_55AA);
    cyc();
    chk("bubble_mem_out", mem_out, 32'd0);

    // Completed load held by an external stall: no re-issue
    hs_clr = 1'b1;
    cyc();
    hs_clr         = 1'b0;
    info           = mk(1'b1, 1'b1, 1'b0, 3'b010, 5'd8);
    alu_in         = 32'h0000_0300;
    dbus_req_ready = 1'b1;
    cyc();
    dbus_req_ready  = 1'b0;
    dbus_resp_valid = 1'b1;
    dbus_rdata      = 32'h0BAD_F00D;
    cyc();
    dbus_resp_valid = 1'b0;
    dbus_rdata      = '0;
    ext_stall       = 1'b1;
    dbus_req_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_stall", 32'(req.stall_req), 32'd0);
      chk("hold_valid", 32'(dbus_req_valid), 32'd0);
      cyc();
    end
    ext_stall      = 1'b0;
    dbus_req_ready = 1'b0;
    cyc();
    bubble();
    #1;
    chk("hold_mem_out", mem_out, 32'h0BAD_F00D);
    chk("hold_requests", 32'(hs_count), 32'd1);

    // Flush during WAIT_RESP, late response discarded
    info   = mk(1'b1, 1'b0, 1'b0, 3'b000, 5'd2);
    alu_in = 32'h0000_CAFE;
    cyc();
    info           = mk(1'b1, 1'b1, 1'b0, 3'b010, 5'd9);
    alu_in         = 32'h0000_0400;
    dbus_req_ready = 1'b1;
    #1;
    chk("pre_flush_mem_out", mem_out, 32'h0000_CAFE);
    cyc();
    dbus_req_ready = 1'b0;
    ext_flush      = 1'b1;
    cyc();
    ext_flush = 1'b0;
    bubble();
    #1;
    chk("drain_stall", 32'(req.stall_req), 32'd0);
    chk("flush_mem_out", mem_out, 32'd0);
    chk("flush_info_ff", 32'(info_ff), 32'd0);
    cyc();
    dbus_resp_valid = 1'b1;
    dbus_rdata      = 32'h1111_1111;
    cyc();
    dbus_resp_valid = 1'b0;
    dbus_rdata      = '0;
    #1;
    chk("drain_mem_out", mem_out, 32'd0);
    run_load("post_drain_lw", 3'b010, 32'h0000_0404, 32'h2222_2222, 32'h2222_2222);

    // Reset while waiting for a response
    info           = mk(1'b1, 1'b1, 1'b0, 3'b010, 5'd1);
    alu_in         = 32'h0000_0500;
    dbus_req_ready = 1'b1;
    cyc();
    dbus_req_ready = 1'b0;
    #1;
    chk("wr_stall", 32'(req.stall_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(dbus_req_valid), 32'd0);
    chk("rst_mid_stall", 32'(req.stall_req), 32'd0);
    chk("rst_mid_mem_out", mem_out, 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_idle_reissue", 32'(dbus_req_valid), 32'd1);
    bubble();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
